// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 single-path delay-feedback FFT stages.
package fft_pkg;

    localparam int FLOAT_LEN_DEFAULT = 32;

    // One complex sample: {real, imag}, each FLOAT_LEN_DEFAULT bits wide
    typedef logic [2*FLOAT_LEN_DEFAULT-1:0] sample_t;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_PAIR  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        FILL  = ST_FILL,
        PAIR  = ST_PAIR,
        FLUSH = ST_FLUSH
    } sdf_state_e;

endpackage

// File: rtl/sdf_tf_addr_gen.sv
// Registered twiddle ROM address for an SDF stage: (cnt * TF_STEP) mod 2^TF_ADDR_W,
// captured on the cycle a butterfly pair is read so it lines up with the FIFO output.
module sdf_tf_addr_gen
    import fft_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int TF_ADDR_W = 8,
    parameter int TF_STEP   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CNT_W-1:0]     cnt,
    output logic [TF_ADDR_W-1:0] tf_addr
);

    // The cast truncates the product, giving the modulo wrap for free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tf_addr <= '0;
        end else if (en) begin
            tf_addr <= TF_ADDR_W'(32'(cnt) * 32'(TF_STEP));
        end
    end

endmodule

// File: rtl/radix2_sdf_stage_ctrl.sv
// Counter-driven sequencer for one radix-2 SDF stage: fills a half-frame FIFO, then
// reads it in lock-step with the second half to present butterfly pairs.
module radix2_sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter int FLOAT_LEN = FLOAT_LEN_DEFAULT,
    parameter int HALF      = 256,
    parameter int CNT_W     = 8,
    parameter int TF_ADDR_W = 8,
    parameter int TF_STEP   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic [2*FLOAT_LEN-1:0] data_in,
    input  logic                   data_in_valid,
    input  logic                   fifo_full,
    input  logic                   fifo_empty,
    output logic                   fifo_wr_en,
    output logic                   fifo_rd_en,
    output logic                   fifo_flush,
    output logic [2*FLOAT_LEN-1:0] data_out2,
    output logic                   pair_valid,
    output logic [TF_ADDR_W-1:0]   tf_addr,
    output logic                   frame_done,
    output logic                   err
);

    sdf_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             overflow;
    logic             underflow;

    assign cnt_last = (cnt == CNT_W'(HALF - 1));

    // clear wins over any same-cycle sample; FLUSH drops its input
    always_comb begin
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        if (!clear && data_in_valid) begin
            fifo_wr_en = (state == FILL);
            fifo_rd_en = (state == PAIR);
        end
    end

    // A write at cnt 0 is exempt: the FIFO may still report full while draining
    assign overflow  = fifo_wr_en && (cnt != '0) && fifo_full;
    assign underflow = fifo_rd_en && fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            cnt        <= '0;
            fifo_flush <= 1'b0;
            pair_valid <= 1'b0;
            data_out2  <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else if (clear) begin
            state      <= FLUSH;
            cnt        <= '0;
            fifo_flush <= 1'b1;
            pair_valid <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            fifo_flush <= 1'b0;
            pair_valid <= fifo_rd_en;
            frame_done <= fifo_rd_en && cnt_last;
            if (fifo_rd_en) begin
                data_out2 <= data_in;
            end
            if (overflow || underflow) begin
                err <= 1'b1;
            end
            case (state)
                FILL: begin
                    if (data_in_valid) begin
                        cnt <= cnt_last ? '0 : cnt + 1'b1;
                        if (cnt_last) begin
                            state <= PAIR;
                        end
                    end
                end
                PAIR: begin
                    if (data_in_valid) begin
                        cnt <= cnt_last ? '0 : cnt + 1'b1;
                        if (cnt_last) begin
                            state <= FILL;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                    cnt   <= '0;
                end
            endcase
        end
    end

    sdf_tf_addr_gen #(
        .CNT_W    (CNT_W),
        .TF_ADDR_W(TF_ADDR_W),
        .TF_STEP  (TF_STEP)
    ) u_tf_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (fifo_rd_en),
        .cnt    (cnt),
        .tf_addr(tf_addr)
    );

endmodule

// File: tb/tb_radix2_sdf_stage_ctrl.sv
// Scoreboard bench for radix2_sdf_stage_ctrl: a frame-position model predicts pairs,
// a bench-side FIFO supplies x1, and a negedge monitor compares every presented pair.
module tb_radix2_sdf_stage_ctrl;
    import fft_pkg::*;

    localparam int HALF = 256;
    localparam int TFW  = 8;
    localparam int TF_STEP = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    sample_t    data_in;
    logic       data_in_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_wr_en;
    logic       fifo_rd_en;
    logic       fifo_flush;
    sample_t    data_out2;
    logic       pair_valid;
    logic [TFW-1:0] tf_addr;
    logic       frame_done;
    logic       err;

    logic       wr2, rd2, flush2, pv2, done2, err2;
    sample_t    dout2_2;
    logic [TFW-1:0] tf_addr2;

    typedef struct {
        sample_t x1;
        sample_t x2;
        int      k;
        logic    done;
    } pair_t;

    pair_t   expQ[$];
    sample_t x1Q[$];
    sample_t fifoQ[$];
    sample_t frameMem [0:HALF-1];

    int   checkCount = 0;
    int   failCount = 0;
    int   pos = 0;
    logic errExp = 1'b0;
    logic prevClr = 1'b0;

    radix2_sdf_stage_ctrl #(.HALF(HALF), .TF_ADDR_W(TFW), .TF_STEP(TF_STEP)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .data_in(data_in),
        .data_in_valid(data_in_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_flush(fifo_flush),
        .data_out2(data_out2), .pair_valid(pair_valid), .tf_addr(tf_addr),
        .frame_done(frame_done), .err(err)
    );

    // Second instance only exercises the TF_STEP = 2 address wrap
    radix2_sdf_stage_ctrl #(.HALF(HALF), .TF_ADDR_W(TFW), .TF_STEP(2)) dut_step2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .data_in(data_in),
        .data_in_valid(data_in_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_wr_en(wr2), .fifo_rd_en(rd2), .fifo_flush(flush2),
        .data_out2(dout2_2), .pair_valid(pv2), .tf_addr(tf_addr2),
        .frame_done(done2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; drives one cycle of input, checks enables, updates the model
    task automatic applyStimulus(input logic v, input sample_t d, input logic clr,
                                 input logic forceFull, input logic forceEmpty);
        pair_t   p;
        sample_t x1;
        data_in_valid = v;
        data_in       = d;
        clear         = clr;
        fifo_full     = forceFull || (fifoQ.size() >= HALF);
        fifo_empty    = forceEmpty || (fifoQ.size() == 0);
        #1;
        checkOutput("err", err, errExp);
        checkOutput("fifo_flush", fifo_flush, prevClr);
        checkOutput("fifo_wr_en", fifo_wr_en, v && !clr && !prevClr && (pos < HALF));
        checkOutput("fifo_rd_en", fifo_rd_en, v && !clr && !prevClr && (pos >= HALF));

        if (fifo_flush) fifoQ.delete();
        if (fifo_wr_en) fifoQ.push_back(d);
        if (fifo_rd_en) begin
            x1 = (fifoQ.size() > 0) ? fifoQ.pop_front() : '0;
            x1Q.push_back(x1);
        end

        if (clr) begin
            pos    = 0;
            errExp = 1'b0;
        end else if (!prevClr && v) begin
            if (pos < HALF) begin
                if (pos != 0 && fifo_full) errExp = 1'b1;
                frameMem[pos] = d;
            end else begin
                if (fifo_empty) errExp = 1'b1;
                p.k    = pos - HALF;
                p.x1   = frameMem[p.k];
                p.x2   = d;
                p.done = (pos == 2*HALF - 1);
                expQ.push_back(p);
            end
            pos = (pos + 1) % (2*HALF);
        end
        prevClr = clr;
        @(negedge clk);
    endtask

    task automatic asyncReset();
        data_in_valid = 1'b0;
        clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset pair_valid", pair_valid, 0);
        checkOutput("reset data_out2", data_out2, 0);
        checkOutput("reset tf_addr", tf_addr, 0);
        checkOutput("reset frame_done", frame_done, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset fifo_flush", fifo_flush, 0);
        checkOutput("reset fifo_wr_en", fifo_wr_en, 0);
        checkOutput("reset fifo_rd_en", fifo_rd_en, 0);
        pos = 0;
        errExp = 1'b0;
        prevClr = 1'b0;
        expQ.delete();
        x1Q.delete();
        fifoQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every presented pair is popped and compared against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (pair_valid) begin
                if (expQ.size() == 0 || x1Q.size() == 0) begin
                    checkCount++;
                    failCount++;
                    $display("[TB] FAIL pair_valid: got 1 with no pending pair, expected 0 at %0t", $time);
                end else begin
                    pair_t   e;
                    sample_t x1;
                    e  = expQ.pop_front();
                    x1 = x1Q.pop_front();
                    checkOutput("x1", x1, e.x1);
                    checkOutput("x2", data_out2, e.x2);
                    checkOutput("tf_addr", tf_addr, 64'((e.k * TF_STEP) % (1 << TFW)));
                    checkOutput("tf_addr step2", tf_addr2, 64'((e.k * 2) % (1 << TFW)));
                    checkOutput("frame_done", frame_done, e.done);
                end
            end else begin
                checkOutput("frame_done idle", frame_done, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepted;
        int cycles;
        logic v;
        rst_n = 1'b0;
        clear = 1'b0;
        data_in = '0;
        data_in_valid = 1'b0;
        fifo_full = 1'b0;
        fifo_empty = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("reset pair_valid", pair_valid, 0);
        checkOutput("reset data_out2", data_out2, 0);
        checkOutput("reset tf_addr", tf_addr, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset fifo_flush", fifo_flush, 0);
        checkOutput("reset fifo_wr_en", fifo_wr_en, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] continuous frames");
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 2*HALF; i++)
                applyStimulus(1'b1, sample_t'(i), 1'b0, 1'b0, 1'b0);

        $display("[TB] random stalls");
        accepted = 0;
        cycles = 0;
        while (accepted < 4*HALF && cycles < 8000) begin
            v = 1'($urandom_range(0, 1));
            applyStimulus(v, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
            if (v) accepted++;
            cycles++;
        end
        checkOutput("stall run length", 64'(accepted), 64'(4*HALF));

        $display("[TB] clear at fill cnt 100");
        for (int i = 0; i < 100; i++)
            applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2*HALF; i++)
            applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);

        $display("[TB] forced underflow");
        for (int i = 0; i < 2*HALF; i++)
            applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, (i == HALF + 5));
        for (int i = 0; i < 2*HALF; i++)
            applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < HALF + 44; i++)
            applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        asyncReset();

        $display("[TB] forced overflow and clear with valid");
        applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 10; i++)
            applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        checkOutput("pending pairs", 64'(expQ.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/radix2_sdf_stage_ctrl.md
Name: radix2_sdf_stage_ctrl

Overview:
- Sequencer for one radix-2 delay-feedback FFT stage built around an external HALF-deep FIFO (FIFO_256-class, 1-cycle read latency).
- First half of each frame: samples are written into the FIFO. Second half: the FIFO is read in lock-step with incoming samples, presenting butterfly pairs (x1 = delayed sample, x2 = current sample) plus a twiddle address.
- Replaces edge-triggered full/empty sequencing with a counter-driven, fully synchronous FSM, with stall support and error detection.

Parameters:
FLOAT_LEN, 32, bits per real/imag float; a sample is 2*FLOAT_LEN bits.
HALF, 256, FIFO depth = half the frame length at this stage.
CNT_W, 8, log2(HALF).
TF_ADDR_W, 8, twiddle ROM address width.
TF_STEP, 1, twiddle address increment per pair (power of two).

Ports:
clk  in  1  stage clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort: flush the FIFO and restart the frame
data_in  in  2*FLOAT_LEN  input sample
data_in_valid  in  1  input sample qualifier
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_wr_en  out  1  FIFO write enable (FIFO din is driven directly by data_in)
fifo_rd_en  out  1  FIFO read enable
fifo_flush  out  1  one-cycle synchronous FIFO reset
data_out2  out  2*FLOAT_LEN  x2, aligned with the FIFO dout (x1)
pair_valid  out  1  x1/x2/tf_addr valid
tf_addr  out  TF_ADDR_W  twiddle address for the current pair
frame_done  out  1  pulse on the last pair of a frame
err  out  1  sticky sequencing error

Behaviour:
- Reset (rst_n = 0, asynchronous): state = FILL, cnt = 0; all outputs 0; data_out2 = 0; err = 0.
- States: FILL, PAIR, FLUSH. cnt is CNT_W bits and advances only on data_in_valid.
- FILL:
  - fifo_wr_en = data_in_valid (combinational); fifo_rd_en = 0.
  - On a valid sample with cnt == HALF-1: cnt -> 0, go to PAIR.
- PAIR:
  - fifo_rd_en = data_in_valid; fifo_wr_en = 0.
  - On a valid sample with cnt == HALF-1: cnt -> 0, go to FILL. Back-to-back frames need no idle cycle.
- Alignment (1-cycle latency):
  - pair_valid registers fifo_rd_en.
  - data_out2 registers data_in when fifo_rd_en = 1; otherwise it holds its value.
  - tf_addr registers (cnt*TF_STEP) mod 2^TF_ADDR_W on the read cycle.
  - frame_done registers (PAIR && data_in_valid && cnt == HALF-1).
- Stall: data_in_valid = 0 freezes cnt and state; no wr/rd pulse; pair_valid = 0 the next cycle.
- FLUSH:
  - Entered from any state when clear = 1. fifo_flush = 1 for exactly one cycle; wr/rd = 0; cnt -> 0; pair_valid = 0.
  - Next state is FILL. Input during FLUSH is dropped.
  - clear has priority over all other events in the same cycle.
- err (sticky until rst_n or clear) is set on any of:
  - fifo_full = 1 while in FILL with cnt != 0 and data_in_valid = 1, i.e. a write would overflow;
  - fifo_empty = 1 while in PAIR with data_in_valid = 1, i.e. a read would underflow.
  - Sequencing continues after err is set; the FIFO flags never gate the enables.
- Reset mid-frame: everything returns to the reset values immediately. The FIFO shares rst_n-derived reset externally.

Decomposition:
- Shared package fft_pkg:
  - FLOAT_LEN default;
  - the sample type (2*FLOAT_LEN bits);
  - the state encoding localparams ST_FILL = 2'd0, ST_PAIR = 2'd1, ST_FLUSH = 2'd2.
- One sub-module is natural: sdf_tf_addr_gen (counter-to-twiddle address, registered), reusable by the other stages with a different TF_STEP.
- The FSM and counter stay in the top module.

Test Plan:
- Continuous frames: 2 frames of data_in_valid = 1, data_in = index 0..511 -> 256 wr pulses, then 256 rd pulses. pair_valid pairs (x1 = k, x2 = k+256) for k = 0..255. tf_addr = 0..255. frame_done asserts on k = 255 (cycle 513 after the first sample). Second frame is identical.
- Stalls: data_in_valid randomly 50% -> same pair sequence and tf_addr values. pair_valid count = 256 per frame. No wr/rd pulse while data_in_valid = 0.
- TF_STEP = 2 with TF_ADDR_W = 8 -> tf_addr = 0,2,...,254,0,...,254 (wraps at 128 pairs).
- clear asserted at FILL cnt = 100 -> fifo_flush pulses 1 cycle. The next 256 valid samples are written from cnt = 0. err stays 0.
- Forced fifo_empty = 1 during PAIR with valid -> err = 1 next cycle and stays 1 through further frames. rst_n low -> err = 0 and all outputs 0 asynchronously.
- fifo_full = 1 injected at FILL cnt = 10 with valid -> err = 1. Same-cycle clear + valid -> FLUSH taken, no wr_en.
